// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the byte-addressable data RAM.
// Port 0 is the CPU data port, port 1 the loader/debug port; one access per two cycles.
module dmem_arbiter #(
   parameter int ADDR_BITS  = 7,
   parameter bit PRIO_FIXED = 1'b0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        p0_req,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic        p0_we,
   input  logic [2:0]  p0_ubhw,
   input  logic        p1_req,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   input  logic        p1_we,
   input  logic [2:0]  p1_ubhw,
   output logic        p0_gnt,
   output logic        p1_gnt,
   output logic        p0_rvalid,
   output logic        p1_rvalid,
   output logic        p0_err,
   output logic        p1_err,
   output logic [31:0] rdata,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   output logic        ram_we,
   output logic [2:0]  ram_ubhw,
   input  logic [31:0] ram_dout
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic        r_last;
   logic [31:0] r_cmdAddr;
   logic [31:0] r_cmdWdata;
   logic        r_cmdWe;
   logic [2:0]  r_cmdUbhw;
   logic        r_cmdPort;
   logic [31:0] r_rdata;
   logic        r_p0Rvalid;
   logic        r_p1Rvalid;
   logic        r_p0Err;
   logic        r_p1Err;

   logic        w_winner;
   logic        w_grant;
   logic        w_access;
   logic        w_misaligned;
   logic        w_outOfRange;
   logic        w_err;

   always_comb begin
      w_winner = 1'b0;
      if (PRIO_FIXED) begin
         w_winner = ~p0_req;
      end else if (p0_req && p1_req) begin
         w_winner = ~r_last;
      end else begin
         w_winner = ~p0_req;
      end
   end

   // Bit1 (word) overrides bit0 (half) when judging alignment.
   always_comb begin
      w_misaligned = r_cmdUbhw[1] ? (r_cmdAddr[1:0] != 2'b00) : (r_cmdUbhw[0] & r_cmdAddr[0]);
      w_outOfRange = (r_cmdAddr >> ADDR_BITS) != 32'd0;
      w_err        = w_misaligned | w_outOfRange;
   end

   assign w_access = (r_state == ACCESS);
   assign w_grant  = p0_gnt | p1_gnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Grants are held off while reset is asserted so nothing is accepted mid-reset.
   always_comb begin
      w_nextState = r_state;
      p0_gnt      = 1'b0;
      p1_gnt      = 1'b0;
      ram_we      = 1'b0;
      case (r_state)
         IDLE: begin
            p0_gnt = rstn & p0_req & ~w_winner;
            p1_gnt = rstn & p1_req & w_winner;
            if (p0_req || p1_req) begin
               w_nextState = ACCESS;
            end
         end
         ACCESS: begin
            ram_we      = r_cmdWe & ~w_err;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_last     <= 1'b1;
         r_cmdAddr  <= 32'd0;
         r_cmdWdata <= 32'd0;
         r_cmdWe    <= 1'b0;
         r_cmdUbhw  <= 3'd0;
         r_cmdPort  <= 1'b0;
      end else if (w_grant) begin
         r_last     <= w_winner;
         r_cmdPort  <= w_winner;
         r_cmdAddr  <= w_winner ? p1_addr  : p0_addr;
         r_cmdWdata <= w_winner ? p1_wdata : p0_wdata;
         r_cmdWe    <= w_winner ? p1_we    : p0_we;
         r_cmdUbhw  <= w_winner ? p1_ubhw  : p0_ubhw;
      end
   end

   // Response registers pulse for exactly the cycle after ACCESS; stores and faults return zero data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rdata    <= 32'd0;
         r_p0Rvalid <= 1'b0;
         r_p1Rvalid <= 1'b0;
         r_p0Err    <= 1'b0;
         r_p1Err    <= 1'b0;
      end else begin
         r_p0Rvalid <= w_access & ~r_cmdPort;
         r_p1Rvalid <= w_access & r_cmdPort;
         r_p0Err    <= w_access & ~r_cmdPort & w_err;
         r_p1Err    <= w_access & r_cmdPort & w_err;
         r_rdata    <= (w_access && !(r_cmdWe || w_err)) ? ram_dout : 32'd0;
      end
   end

   assign p0_rvalid = r_p0Rvalid;
   assign p1_rvalid = r_p1Rvalid;
   assign p0_err    = r_p0Err;
   assign p1_err    = r_p1Err;
   assign rdata     = r_rdata;
   assign ram_addr  = r_cmdAddr;
   assign ram_din   = r_cmdWdata;
   assign ram_ubhw  = r_cmdUbhw;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, vector table, scoreboard of responses and
// hand-written sequences for arbitration and reset during an access.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        p0_req, p1_req;
   logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic        p0_we, p1_we;
   logic [2:0]  p0_ubhw, p1_ubhw;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
   logic [31:0] rdata, ram_addr, ram_din, ram_dout;
   logic        ram_we;
   logic [2:0]  ram_ubhw;

   logic        f_p0_gnt, f_p1_gnt, f_p0_rvalid, f_p1_rvalid, f_p0_err, f_p1_err;
   logic [31:0] f_rdata, f_ram_addr, f_ram_din;
   logic        f_ram_we;
   logic [2:0]  f_ram_ubhw;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_BITS(7), .PRIO_FIXED(1'b0)) dut (
      .clk(clk), .rstn(rstn),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_ubhw(p0_ubhw),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_ubhw(p1_ubhw),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_err(p0_err), .p1_err(p1_err), .rdata(rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_ubhw(ram_ubhw),
      .ram_dout(ram_dout)
   );

   dmem_arbiter #(.ADDR_BITS(7), .PRIO_FIXED(1'b1)) dutFixed (
      .clk(clk), .rstn(rstn),
      .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_ubhw(p0_ubhw),
      .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_ubhw(p1_ubhw),
      .p0_gnt(f_p0_gnt), .p1_gnt(f_p1_gnt), .p0_rvalid(f_p0_rvalid), .p1_rvalid(f_p1_rvalid),
      .p0_err(f_p0_err), .p1_err(f_p1_err), .rdata(f_rdata),
      .ram_addr(f_ram_addr), .ram_din(f_ram_din), .ram_we(f_ram_we), .ram_ubhw(f_ram_ubhw),
      .ram_dout(32'h0)
   );

   // RAM model: little-endian bytes, combinational sized/signed read, negedge write.
   logic [7:0] mem [0:127];
   logic [6:0] ra;
   assign ra = ram_addr[6:0];

   always_comb begin
      ram_dout = 32'h0;
      if (ram_ubhw[1]) begin
         ram_dout = {mem[ra + 7'd3], mem[ra + 7'd2], mem[ra + 7'd1], mem[ra]};
      end else if (ram_ubhw[0]) begin
         ram_dout = ram_ubhw[2] ? {16'h0, mem[ra + 7'd1], mem[ra]}
                                : {{16{mem[ra + 7'd1][7]}}, mem[ra + 7'd1], mem[ra]};
      end else begin
         ram_dout = ram_ubhw[2] ? {24'h0, mem[ra]} : {{24{mem[ra][7]}}, mem[ra]};
      end
   end

   always @(negedge clk) begin
      if (ram_we) begin
         mem[ra] <= ram_din[7:0];
         if (ram_ubhw[1] || ram_ubhw[0]) mem[ra + 7'd1] <= ram_din[15:8];
         if (ram_ubhw[1]) begin
            mem[ra + 7'd2] <= ram_din[23:16];
            mem[ra + 7'd3] <= ram_din[31:24];
         end
      end
   end

   typedef struct {
      logic        port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [2:0]  ubhw;
      logic        expErr;
      logic [31:0] expRdata;
   } vec_t;

   typedef struct {
      logic        port;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sbQ[$];
   exp_t mE;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[15];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drivePort(input logic port, input logic req, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic we, input logic [2:0] ubhw);
      if (!port) begin
         p0_req = req; p0_addr = addr; p0_wdata = wdata; p0_we = we; p0_ubhw = ubhw;
      end else begin
         p1_req = req; p1_addr = addr; p1_wdata = wdata; p1_we = we; p1_ubhw = ubhw;
      end
   endtask

   // One single-port access with cycle-by-cycle latency checks; the response itself goes to the scoreboard.
   task automatic applyStimulus(input vec_t v);
      logic got;
      exp_t e;
      @(posedge clk); #1;
      drivePort(v.port, 1'b1, v.addr, v.wdata, v.we, v.ubhw);
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         got = v.port ? p1_gnt : p0_gnt;
      end
      checkBit("gnt", got, 1'b1);
      if (!got) begin
         drivePort(v.port, 1'b0, v.addr, v.wdata, v.we, v.ubhw);
         return;
      end
      e.port = v.port; e.err = v.expErr; e.rdata = v.expRdata;
      sbQ.push_back(e);
      @(posedge clk); @(negedge clk);
      checkBit("ramWe", ram_we, v.we & ~v.expErr);
      checkOutput("ramAddr", ram_addr, v.addr);
      checkOutput("ramDin", ram_din, v.wdata);
      checkOutput("ramUbhw", 32'(ram_ubhw), 32'(v.ubhw));
      checkBit("gntInAccess", p0_gnt | p1_gnt, 1'b0);
      drivePort(v.port, 1'b0, v.addr, v.wdata, v.we, v.ubhw);
      @(posedge clk); @(negedge clk);
      checkBit("rvalidLatency", v.port ? p1_rvalid : p0_rvalid, 1'b1);
   endtask

   // Every response pulse is matched in order against the scoreboard.
   always @(negedge clk) begin
      if (p0_rvalid || p1_rvalid) begin
         if (sbQ.size() == 0) begin
            checkBit("unexpectedRvalid", p0_rvalid | p1_rvalid, 1'b0);
         end else begin
            mE = sbQ.pop_front();
            checkBit("rvalidP1", p1_rvalid, mE.port);
            checkBit("rvalidP0", p0_rvalid, ~mE.port);
            checkBit("err", mE.port ? p1_err : p0_err, mE.err);
            checkOutput("rdata", rdata, mE.rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int gcount;
      logic got;
      exp_t e;

      tbl[0]  = '{1'b0, 32'h10,        32'hDEADBEEF, 1'b1, 3'b010, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'h10,        32'h0,        1'b0, 3'b010, 1'b0, 32'hDEADBEEF};
      tbl[2]  = '{1'b0, 32'h13,        32'h0,        1'b0, 3'b000, 1'b0, 32'hFFFFFFDE};
      tbl[3]  = '{1'b1, 32'h13,        32'h0,        1'b0, 3'b100, 1'b0, 32'h000000DE};
      tbl[4]  = '{1'b0, 32'h12,        32'h0,        1'b0, 3'b001, 1'b0, 32'hFFFFDEAD};
      tbl[5]  = '{1'b1, 32'h11,        32'h12345678, 1'b1, 3'b010, 1'b1, 32'h0};
      tbl[6]  = '{1'b0, 32'h21,        32'h0000AAAA, 1'b1, 3'b001, 1'b1, 32'h0};
      tbl[7]  = '{1'b1, 32'h80,        32'h0,        1'b0, 3'b010, 1'b1, 32'h0};
      tbl[8]  = '{1'b0, 32'h10,        32'h0,        1'b0, 3'b010, 1'b0, 32'hDEADBEEF};
      tbl[9]  = '{1'b1, 32'h12,        32'h0,        1'b0, 3'b101, 1'b0, 32'h0000DEAD};
      tbl[10] = '{1'b1, 32'h14,        32'h00000055, 1'b1, 3'b000, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 32'h14,        32'h0,        1'b0, 3'b010, 1'b0, 32'h00000055};
      tbl[12] = '{1'b1, 32'h12,        32'h0,        1'b0, 3'b011, 1'b1, 32'h0};
      tbl[13] = '{1'b0, 32'h7C,        32'h0,        1'b0, 3'b010, 1'b0, 32'h0};
      tbl[14] = '{1'b1, 32'h10000010,  32'h0,        1'b0, 3'b010, 1'b1, 32'h0};

      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      drivePort(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
      drivePort(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
      rstn = 1'b0;

      #12;
      checkBit("rstP0Gnt", p0_gnt, 1'b0);
      checkBit("rstP1Gnt", p1_gnt, 1'b0);
      checkBit("rstP0Rvalid", p0_rvalid, 1'b0);
      checkBit("rstP1Rvalid", p1_rvalid, 1'b0);
      checkBit("rstP0Err", p0_err, 1'b0);
      checkBit("rstP1Err", p1_err, 1'b0);
      checkBit("rstRamWe", ram_we, 1'b0);
      checkOutput("rstRdata", rdata, 32'h0);
      checkOutput("rstRamAddr", ram_addr, 32'h0);
      checkOutput("rstRamDin", ram_din, 32'h0);
      checkOutput("rstRamUbhw", 32'(ram_ubhw), 32'h0);
      @(posedge clk); #3;
      rstn = 1'b1;

      for (int i = 0; i < 15; i++) applyStimulus(tbl[i]);

      // Reset lands in the middle of a port 1 load: outputs clear at once and no response follows.
      @(posedge clk); #1;
      drivePort(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         got = p1_gnt;
      end
      checkBit("rstSeqGnt", got, 1'b1);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      checkBit("midRstRamWe", ram_we, 1'b0);
      checkOutput("midRstRamAddr", ram_addr, 32'h0);
      checkOutput("midRstRamUbhw", 32'(ram_ubhw), 32'h0);
      checkOutput("midRstRdata", rdata, 32'h0);
      drivePort(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
      @(posedge clk); #1;
      checkBit("midRstNoRvalid", p1_rvalid, 1'b0);
      @(posedge clk); #3;
      rstn = 1'b1;

      // Both ports request continuously: round-robin alternates every two cycles, fixed priority keeps port 0.
      @(posedge clk); #1;
      drivePort(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 3'b010);
      drivePort(1'b1, 1'b1, 32'h14, 32'h0, 1'b0, 3'b010);
      gcount = 0;
      for (int n = 0; n < 11; n++) begin
         @(negedge clk);
         checkBit("fixP1Gnt", f_p1_gnt, 1'b0);
         checkBit("fixP0Gnt", f_p0_gnt, (n % 2) == 0);
         if (p0_gnt || p1_gnt) begin
            checkOutput("rrGap", 32'(n), 32'(2 * gcount));
            checkBit("rrOrder", p1_gnt, gcount[0]);
            e.port  = gcount[0];
            e.err   = 1'b0;
            e.rdata = gcount[0] ? 32'h00000055 : 32'hDEADBEEF;
            sbQ.push_back(e);
            gcount++;
         end
         @(posedge clk); #1;
      end
      drivePort(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
      drivePort(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 3'b000);
      checkOutput("rrCount", 32'(gcount), 32'd6);

      repeat (4) @(posedge clk);
      #1;
      checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the byte-addressable data RAM (RAM_B-style: combinational read, negedge write, `mem_u_b_h_w` size/sign control). It shares the single RAM between the CPU data port (port 0) and the loader/debug port (port 1). It checks alignment and range before touching the RAM, and returns registered read data or an error with a one-cycle valid pulse. It sits between the MEM stage / debug unit and the RAM instance.

## Interface
Parameters:
- `ADDR_BITS`, 7: RAM byte-address width. Any address with `addr[31:ADDR_BITS] != 0` is out of range.
- `PRIO_FIXED`, 0: 0 selects round-robin arbitration; 1 means port 0 always wins.

Ports:
- `clk`  in  1  system clock. The RAM's `clka` is driven from the same net.
- `rstn`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  request valid. Held until granted.
- `p0_addr`, `p1_addr`  in  32  byte address.
- `p0_wdata`, `p1_wdata`  in  32  write data, LSB-aligned.
- `p0_we`, `p1_we`  in  1  1 = store, 0 = load.
- `p0_ubhw`, `p1_ubhw`  in  3  access size/sign:
  - bit1 = word, bit0 = half, bit2 = unsigned.
  - 000 = signed byte.
  - bit1 set takes precedence over bit0.
- `p0_gnt`, `p1_gnt`  out  1  request accepted this cycle (combinational).
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle response pulse.
- `p0_err`, `p1_err`  out  1  qualifies rvalid: misaligned or out-of-range.
- `rdata`  out  32  shared response data. Valid only when some `rvalid` is high.
- `ram_addr`  out  32  to RAM `addra`.
- `ram_din`  out  32  to RAM `dina`.
- `ram_we`  out  1  to RAM `wea`.
- `ram_ubhw`  out  3  to RAM `mem_u_b_h_w`.
- `ram_dout`  in  32  from RAM `douta`.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE:
  - Grant computation:
    - If PRIO_FIXED=1: winner = port 0 whenever `p0_req`.
    - Otherwise: with both requesting, winner = the port not in `last`; with one requesting, that port wins.
  - `pX_gnt` = (state==IDLE) & `pX_req` & winner==X. At most one grant is high per cycle.
  - On a grant, register the winner's addr, wdata, we, ubhw and port id into a command register. Update `last` to the winner. Go to ACCESS.
- Fault check (combinational on the registered command):
  - Misaligned: word with `addr[1:0]!=0`, or half with `addr[0]!=0`.
  - Out of range: `addr[31:ADDR_BITS]!=0`.
  - err = misaligned | out of range.
- ACCESS (exactly one cycle):
  - `ram_addr`, `ram_din` and `ram_ubhw` come from the command register.
  - `ram_we` = cmd_we & ~err, so the RAM commits on the falling edge inside this cycle.
  - At the closing rising edge:
    - `rdata` ← (cmd_we | err) ? 0 : `ram_dout`.
    - rvalid and err are set for cmd_port.
    - Return to IDLE.
- Stores also get an rvalid pulse, which serves as the write acknowledgement; `rdata` is 0 for stores.
- Outside ACCESS: `ram_we`=0; `ram_addr`, `ram_din` and `ram_ubhw` hold the last command.

## Timing
- Reset values (asynchronous, applied immediately when `rstn`=0):
  - state=IDLE, `last`=port 1 (so port 0 wins the first tie), command register=0.
  - All gnt, rvalid and err = 0; `rdata`=0; `ram_we`=0; `ram_addr`=0; `ram_din`=0; `ram_ubhw`=0.
- Latency: grant in cycle k → ACCESS in cycle k+1 → rvalid/err/rdata high during cycle k+2 only.
- Back-to-back: in cycle k+2 the FSM is IDLE, so a new grant can coincide with the previous rvalid. Peak throughput is one access per 2 cycles.
- Grant is never given in ACCESS. A requester whose req is not granted must hold req and its fields stable.
- A faulted store never asserts `ram_we`; RAM contents are unchanged.
- Reset asserted during ACCESS: `ram_we` drops asynchronously. The pending store may or may not have reached the RAM (negedge-dependent). No rvalid is issued for it.
- Simultaneous requests with round-robin: grants alternate 0,1,0,1…; neither port waits more than one other access.

## Test plan
- Reset, then `p0_req` word store, addr 0x10, data 0xDEADBEEF → `p0_gnt` in cycle 0, `ram_we`=1 in cycle 1, `p0_rvalid`=1 with err=0 in cycle 2. A following word load of 0x10 returns `rdata`=0xDEADBEEF.
- Signed byte load at 0x13 (byte 0xDE) → `rdata`=0xFFFFFFDE. The same load with ubhw=100 → 0x000000DE. A half load at 0x12 with ubhw=001 → 0xFFFFDEAD.
- Both ports request continuously for 6 grants, PRIO_FIXED=0 → grant order 0,1,0,1,0,1, one grant every 2 cycles. With PRIO_FIXED=1 → port 0 only while `p0_req` stays high.
- Word store at 0x11, half store at 0x21, word load at 0x80 → each gives err=1 with rvalid, `ram_we` never high, `rdata`=0, and memory at 0x10–0x13 is unchanged.
- Deassert `rstn` during ACCESS of a port 1 load → `ram_we`=0 and outputs 0 immediately, no `p1_rvalid`. After release, the first tie is granted to port 0.
